rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
Multi-precision add sequencer. It drives one byte-wide ripple-carry datapath built from the team's FA cells, iterating over a WORDS-byte operand pair from LSB to MSB and holding the inter-byte carry in a register. It accepts operands on a valid/ready input channel and returns the wide sum on a valid/ready output channel. It sits between operand producers and any consumer that needs adds wider than 8 bits without a wide combinational carry chain.

Parameters:
WORDS, 4, number of 8-bit bytes per operand; legal range 1..64.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair and in_cin present
in_ready  output  1  block can accept operands
in_a  input  8*WORDS  operand A, byte 0 = bits [7:0]
in_b  input  8*WORDS  operand B
in_cin  input  1  carry into byte 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  8*WORDS  A + B + cin, modulo 2^(8*WORDS)
out_cout  output  1  carry out of the MSB byte
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-low:
  - state = IDLE; byte index = 0; carry register = 0.
  - Operand registers, out_sum and out_cout all clear to 0.
  - out_valid = 0 and busy = 0. in_ready = 1, since it decodes IDLE.
- in_ready is a combinational decode of state == IDLE. out_valid is a decode of state == DONE. busy is a decode of state != IDLE.
- IDLE: when in_valid & in_ready at a rising edge:
  - latch in_a and in_b;
  - carry <= in_cin; index <= 0;
  - clear out_sum to 0; out_cout <= 0;
  - go to RUN.
  - With in_valid low, the block stays in IDLE.
- RUN: one byte per cycle. At each edge:
  - out_sum byte[index] <= A[index] + B[index] + carry (low 8 bits);
  - carry <= carry-out of that byte add.
  - If index == WORDS-1: out_cout <= that carry-out and go to DONE. Otherwise index <= index + 1.
  - No early exit, even when remaining bytes are zero.
- DONE: out_sum and out_cout are held stable. When out_valid & out_ready at an edge, go to IDLE. Output registers keep their value until the next accept.
- Latency: out_valid is first high exactly WORDS cycles after the accepting edge, with out_ready ignored until then.
- Back-to-back throughput with out_ready and in_valid held high: one transaction every WORDS+2 cycles (1 accept + WORDS RUN + 1 DONE handshake). There is no overlap of input accept with DONE.
- Inputs during RUN and DONE:
  - in_valid is ignored because in_ready = 0.
  - in_a, in_b and in_cin may change freely; only the latched copies are used.
- out_ready asserted before DONE has no effect. out_valid must not drop until handshake.
- Index counter width is clog2(WORDS) with a minimum of 1 bit. With WORDS = 1, RUN lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE aborts the transaction immediately: all registers go to reset values and no out_valid is produced. The first accept after rst_n rises starts cleanly.
- The arithmetic is unsigned. Overflow is reported only through out_cout, with no saturation.

Test Plan:
1. WORDS=4, A=0x000000FF, B=0x00000001, cin=0, out_ready=1 -> out_valid high 4 cycles after accept; out_sum=0x00000100, out_cout=0; back to IDLE next edge.
2. WORDS=4, A=0xFFFFFFFF, B=0x00000000, cin=1 -> out_sum=0x00000000, out_cout=1. The carry must propagate through all 4 byte steps.
3. Backpressure: A=0x12345678, B=0x11111111, hold out_ready=0 for 10 cycles while pulsing in_valid with other data -> out_valid stays 1; out_sum stays 0x23456789, out_cout=0; in_ready stays 0. The pulses are not accepted. On out_ready=1 the handshake completes and in_ready=1 the next cycle.
4. Back-to-back: in_valid and out_ready high continuously with 3 random operand pairs -> accepts every 6 cycles (WORDS+2); each result matches a reference model including cout.
5. Reset mid-op: drop rst_n for 1 cycle at the 2nd RUN cycle -> immediately out_valid=0, busy=0, out_sum=0, in_ready=1. The next transaction 0x00000001+0x00000001 gives 0x00000002, cout=0.
6. WORDS=1: A=0x80, B=0x80, cin=0 -> out_valid 1 cycle after accept; out_sum=0x00, out_cout=1.

Source files
------------

// File: rtl/rca_seq_ctrl_if.sv
// rtl/rca_seq_ctrl_if.sv - operand/result handshake bundle for the multi-precision add sequencer
//
// Purpose: groups the input operand channel, the result channel and the busy
// flag of rca_seq_ctrl so the block and its neighbours connect through one port.
// Signals:
//   in_valid/in_ready     operand channel handshake
//   in_a/in_b [8*WORDS]   operands, byte 0 = bits [7:0]
//   in_cin                carry into byte 0
//   out_valid/out_ready   result channel handshake
//   out_sum [8*WORDS]     A + B + cin modulo 2^(8*WORDS)
//   out_cout              carry out of the MSB byte
//   busy                  sequencer is in RUN or DONE
// Modports: master = operand producer / result consumer, slave = sequencer.
interface rca_seq_ctrl_if #(
  parameter int WORDS = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [8*WORDS-1:0] in_a;
  logic [8*WORDS-1:0] in_b;
  logic               in_cin;
  logic               out_valid;
  logic               out_ready;
  logic [8*WORDS-1:0] out_sum;
  logic               out_cout;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - byte-serial multi-precision ripple-carry add sequencer
//
// Purpose: adds two WORDS-byte operands one byte per cycle through a single
// 8-bit ripple-carry datapath of full-adder cells, LSB byte first, holding the
// inter-byte carry in a register.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rca_seq_ctrl_if.slave (operand channel, result channel, busy)
// Timing: result valid exactly WORDS cycles after the accepting edge; one
// transaction every WORDS+2 cycles when both channels stream continuously.
module rca_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_seq_ctrl_if.slave bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int W  = 8 * WORDS;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    s_byte;
  logic [8:0]    c_chain;
  logic          accept;
  logic          last_byte;

  assign a_byte    = a_q[idx*8 +: 8];
  assign b_byte    = b_q[idx*8 +: 8];
  assign accept    = bus.in_valid && (state == IDLE);
  assign last_byte = (idx == LAST_IDX);

  // Eight chained full-adder cells; c_chain[8] is the byte carry-out.
  always_comb begin
    s_byte     = '0;
    c_chain    = '0;
    c_chain[0] = carry;
    for (int i = 0; i < 8; i++) begin
      s_byte[i]      = a_byte[i] ^ b_byte[i] ^ c_chain[i];
      c_chain[i + 1] = (a_byte[i] & b_byte[i]) | (c_chain[i] & (a_byte[i] ^ b_byte[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_byte) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            carry  <= bus.in_cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx*8 +: 8] <= s_byte;
          carry             <= c_chain[8];
          // No early exit: every byte is visited so latency is fixed.
          if (last_byte) begin
            cout_q <= c_chain[8];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - directed self-checking bench for rca_seq_ctrl (WORDS=4 and WORDS=1)
module tb_rca_seq_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  rca_seq_ctrl_if #(.WORDS(4)) bus4 ();
  rca_seq_ctrl_if #(.WORDS(1)) bus1 ();

  rca_seq_ctrl #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  rca_seq_ctrl #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair on the WORDS=4 instance and check latency, result and return to IDLE.
  task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [31:0] es, input logic ec);
    int n;
    check({tag, " in_ready before"}, 64'(bus4.in_ready), 64'd1);
    bus4.in_a      = a;
    bus4.in_b      = b;
    bus4.in_cin    = cin;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check({tag, " busy after accept"}, 64'(bus4.busy), 64'd1);
    check({tag, " out_valid after accept"}, 64'(bus4.out_valid), 64'd0);
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd4);
    check({tag, " out_sum"}, 64'(bus4.out_sum), 64'(es));
    check({tag, " out_cout"}, 64'(bus4.out_cout), 64'(ec));
    @(negedge clk);
    check({tag, " in_ready after handshake"}, 64'(bus4.in_ready), 64'd1);
    check({tag, " out_valid after handshake"}, 64'(bus4.out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int acc_cyc [3];
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] rexp;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst in_ready", 64'(bus4.in_ready), 64'd1);
    check("rst out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst busy", 64'(bus4.busy), 64'd0);
    check("rst out_sum", 64'(bus4.out_sum), 64'd0);
    check("rst out_cout", 64'(bus4.out_cout), 64'd0);
    check("rst1 in_ready", 64'(bus1.in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no accept", 64'(bus4.busy), 64'd0);

    // 1: single byte carry into byte 1
    run4("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    // 2: carry ripples through all four bytes
    run4("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);

    // 3: backpressure with ignored input pulses
    bus4.out_ready = 1'b0;
    bus4.in_a = 32'h1234_5678; bus4.in_b = 32'h1111_1111; bus4.in_cin = 1'b0;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3 latency", 64'(n), 64'd4);
    for (int i = 0; i < 10; i++) begin
      bus4.in_valid = i[0];
      bus4.in_a     = 32'hDEAD_0000 + 32'(i);
      bus4.in_b     = 32'h0BAD_F00D;
      bus4.in_cin   = 1'b1;
      check("t3 out_valid held", 64'(bus4.out_valid), 64'd1);
      check("t3 out_sum held", 64'(bus4.out_sum), 64'h2345_6789);
      check("t3 in_ready low", 64'(bus4.in_ready), 64'd0);
      @(negedge clk);
    end
    check("t3 out_cout", 64'(bus4.out_cout), 64'd0);
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("t3 in_ready after handshake", 64'(bus4.in_ready), 64'd1);
    check("t3 out_valid after handshake", 64'(bus4.out_valid), 64'd0);
    check("t3 out_sum kept", 64'(bus4.out_sum), 64'h2345_6789);

    // 4: back-to-back with in_valid and out_ready held high
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (k == 0) ra = 32'hFFFF_FFFF;
      rexp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      check("t4 in_ready", 64'(bus4.in_ready), 64'd1);
      bus4.in_a = ra; bus4.in_b = rb; bus4.in_cin = rc;
      acc_cyc[k] = cyc;
      @(negedge clk);
      n = 0;
      while (!bus4.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t4 latency", 64'(n), 64'd4);
      check("t4 out_sum", 64'(bus4.out_sum), 64'(rexp[31:0]));
      check("t4 out_cout", 64'(bus4.out_cout), 64'(rexp[32]));
      @(negedge clk);
      if (k == 2) bus4.in_valid = 1'b0;
    end
    check("t4 spacing 0-1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
    check("t4 spacing 1-2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);

    // 5: reset during the second RUN cycle
    bus4.in_a = 32'h0102_0304; bus4.in_b = 32'h0101_0101; bus4.in_cin = 1'b0;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("t5 partial sum", 64'(bus4.out_sum), 64'h0000_0005);
    rst_n = 1'b0;
    #1;
    check("t5 out_valid", 64'(bus4.out_valid), 64'd0);
    check("t5 busy", 64'(bus4.busy), 64'd0);
    check("t5 out_sum", 64'(bus4.out_sum), 64'd0);
    check("t5 in_ready", 64'(bus4.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4("t5 post", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0);

    // 6: WORDS=1 instance
    bus1.in_a = 8'h80; bus1.in_b = 8'h80; bus1.in_cin = 1'b0;
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    check("t6 in_ready", 64'(bus1.in_ready), 64'd1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("t6 busy", 64'(bus1.busy), 64'd1);
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6 latency", 64'(n), 64'd1);
    check("t6 out_sum", 64'(bus1.out_sum), 64'h00);
    check("t6 out_cout", 64'(bus1.out_cout), 64'd1);
    @(negedge clk);
    check("t6 in_ready after", 64'(bus1.in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
